// File: rtl/obj_line_fetch.sv
// Sprite line fetcher: walks the object attribute table, picks objects crossing
// the next scanline, fetches one ROM row per 16-px span and emits line-buffer writes.
module obj_line_fetch #(
  parameter int                OBJ_COUNT  = 512,
  parameter int                ADDR_W     = 25,
  parameter int                DATA_W     = 64,
  parameter logic [ADDR_W-1:0] ROM_BASE   = {ADDR_W{1'b0}},
  parameter int                SPAN_LIMIT = 0,
  localparam int               IDX_W      = $clog2(OBJ_COUNT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              line_start,
  input  logic [8:0]        v_line,
  input  logic              flip_screen,
  output logic [IDX_W-1:0]  obj_idx,
  input  logic [63:0]       obj_in,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic              lb_we,
  output logic [9:0]        lb_x,
  output logic [6:0]        lb_color,
  output logic              lb_prio,
  output logic              lb_flip,
  output logic [DATA_W-1:0] lb_data,
  output logic              busy,
  output logic              overflow,
  output logic [9:0]        span_count
);

  localparam bit         LIM_EN = (SPAN_LIMIT > 0) && (SPAN_LIMIT <= 1023);
  localparam logic [9:0] LIM    = LIM_EN ? 10'(SPAN_LIMIT) : 10'd0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_FETCH = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t            state;
  logic [63:0]       ent;
  logic [8:0]        ve;
  logic [2:0]        span;
  logic              stale;
  logic              ack_seen;
  logic [DATA_W-1:0] ack_data;

  logic [63:0]       cur;
  logic [8:0]        h;
  logic [8:0]        rel_y;
  logic [8:0]        row_y;
  logic              hit;
  logic [2:0]        wm1_cur;
  logic [2:0]        wm1_ent;
  logic [2:0]        col;
  logic [15:0]       code_r;
  logic [22:0]       row_off;
  logic [ADDR_W-1:0] addr_nxt;
  logic [IDX_W:0]    sum_cur;
  logic [IDX_W:0]    sum_ent;
  logic [9:0]        sc_inc;
  logic [9:0]        x_nxt;
  logic              unused_bits;

  function automatic logic [3:0] obj_width(input logic [1:0] wl);
    return 4'd1 << wl;
  endfunction

  // Object evaluation and ROM address for the current span; entry comes from
  // the table on the first span and from the latched copy on later spans.
  always_comb begin
    cur      = (span == 3'd0) ? obj_in : ent;
    h        = 9'd16 << cur[10:9];
    rel_y    = ve + cur[8:0] + h;
    hit      = (rel_y < h);
    row_y    = cur[41] ? (h - 9'd1 - rel_y) : rel_y;
    wm1_cur  = 3'(obj_width(cur[12:11]) - 4'd1);
    col      = cur[40] ? (wm1_cur - span) : span;
    code_r   = cur[31:16] + {11'd0, row_y[8:4]} + {10'd0, col, 3'd0};
    row_off  = {code_r, row_y[3:0], 3'b000};
    addr_nxt = ROM_BASE + ADDR_W'(row_off);
    wm1_ent  = 3'(obj_width(ent[12:11]) - 4'd1);
    sum_cur  = {1'b0, obj_idx} + (IDX_W+1)'(obj_width(cur[12:11]));
    sum_ent  = {1'b0, obj_idx} + (IDX_W+1)'(obj_width(ent[12:11]));
    sc_inc   = (span_count == 10'h3FF) ? span_count : span_count + 10'd1;
    x_nxt    = ent[57:48] + {3'd0, span, 4'd0};
  end

  assign unused_bits = ^{cur[15:13], cur[47:42], cur[63:58]};

  // Sequencer: ROM ack capture on every clk, state advance only on ce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ent        <= 64'd0;
      ve         <= 9'd0;
      span       <= 3'd0;
      stale      <= 1'b0;
      ack_seen   <= 1'b0;
      ack_data   <= {DATA_W{1'b0}};
      obj_idx    <= {IDX_W{1'b0}};
      rom_addr   <= {ADDR_W{1'b0}};
      rom_req    <= 1'b0;
      lb_we      <= 1'b0;
      lb_x       <= 10'd0;
      lb_color   <= 7'd0;
      lb_prio    <= 1'b0;
      lb_flip    <= 1'b0;
      lb_data    <= {DATA_W{1'b0}};
      busy       <= 1'b0;
      overflow   <= 1'b0;
      span_count <= 10'd0;
    end else begin
      lb_we <= 1'b0;
      // An ack owed to an abandoned request only clears the stale marker.
      if (rom_ack) begin
        if (stale) begin
          stale <= 1'b0;
        end else if (rom_req) begin
          ack_seen <= 1'b1;
          ack_data <= rom_data;
          rom_req  <= 1'b0;
        end
      end
      if (ce) begin
        if (line_start) begin
          obj_idx    <= {IDX_W{1'b0}};
          span       <= 3'd0;
          span_count <= 10'd0;
          overflow   <= 1'b0;
          busy       <= 1'b1;
          ve         <= v_line ^ {9{flip_screen}};
          ack_seen   <= 1'b0;
          rom_req    <= 1'b0;
          if (rom_req && !rom_ack) begin
            stale <= 1'b1;
          end
          state <= S_LOAD;
        end else begin
          case (state)
            S_IDLE: state <= S_IDLE;
            S_LOAD: state <= S_EVAL;
            S_EVAL: begin
              if (span == 3'd0) begin
                ent <= obj_in;
              end
              if (hit) begin
                if (!stale) begin
                  rom_addr <= addr_nxt;
                  rom_req  <= 1'b1;
                  state    <= S_FETCH;
                end else begin
                  state <= S_EVAL;
                end
              end else begin
                obj_idx <= sum_cur[IDX_W-1:0];
                if (sum_cur[IDX_W]) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end else begin
                  state <= S_LOAD;
                end
              end
            end
            S_FETCH: begin
              if (ack_seen) begin
                ack_seen <= 1'b0;
                state    <= S_WRITE;
              end else begin
                state <= S_FETCH;
              end
            end
            S_WRITE: begin
              lb_we      <= 1'b1;
              lb_x       <= x_nxt;
              lb_color   <= ent[38:32];
              lb_prio    <= ent[39];
              lb_flip    <= ent[40];
              lb_data    <= ack_data;
              span_count <= sc_inc;
              if (LIM_EN && (sc_inc >= LIM)) begin
                overflow <= 1'b1;
                busy     <= 1'b0;
                span     <= 3'd0;
                state    <= S_IDLE;
              end else if (span == wm1_ent) begin
                span    <= 3'd0;
                obj_idx <= sum_ent[IDX_W-1:0];
                if (sum_ent[IDX_W]) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end else begin
                  state <= S_LOAD;
                end
              end else begin
                span  <= span + 3'd1;
                state <= S_EVAL;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_obj_line_fetch.sv
// Scoreboard bench for obj_line_fetch: a spec-level line model queues expected
// line-buffer writes, a monitor pops and compares them as lb_we fires.
module tb_obj_line_fetch;

  localparam logic [24:0] BASE = 25'h0400000;

  logic        clk = 1'b0, reset_n = 1'b0, ce = 1'b0, line_start = 1'b0, flip_screen = 1'b0;
  logic [8:0]  v_line = 9'd0;

  logic [8:0]  obj_idx, l_obj_idx;
  logic [63:0] obj_in = 64'd0, l_obj_in = 64'd0;
  logic [24:0] rom_addr, l_rom_addr;
  logic        rom_req, l_rom_req, rom_ack = 1'b0, l_rom_ack = 1'b0;
  logic [63:0] rom_data = 64'd0, l_rom_data = 64'd0;
  logic        lb_we, l_lb_we, lb_prio, l_lb_prio, lb_flip, l_lb_flip;
  logic [9:0]  lb_x, l_lb_x, span_count, l_span_count;
  logic [6:0]  lb_color, l_lb_color;
  logic [63:0] lb_data, l_lb_data;
  logic        busy, l_busy, overflow, l_overflow;

  obj_line_fetch #(.OBJ_COUNT(512), .ADDR_W(25), .DATA_W(64), .ROM_BASE(BASE), .SPAN_LIMIT(0)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .line_start(line_start), .v_line(v_line),
    .flip_screen(flip_screen), .obj_idx(obj_idx), .obj_in(obj_in), .rom_addr(rom_addr),
    .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data), .lb_we(lb_we), .lb_x(lb_x),
    .lb_color(lb_color), .lb_prio(lb_prio), .lb_flip(lb_flip), .lb_data(lb_data),
    .busy(busy), .overflow(overflow), .span_count(span_count));

  obj_line_fetch #(.OBJ_COUNT(512), .ADDR_W(25), .DATA_W(64), .ROM_BASE(25'h0), .SPAN_LIMIT(3)) dut_lim (
    .clk(clk), .reset_n(reset_n), .ce(ce), .line_start(line_start), .v_line(v_line),
    .flip_screen(flip_screen), .obj_idx(l_obj_idx), .obj_in(l_obj_in), .rom_addr(l_rom_addr),
    .rom_req(l_rom_req), .rom_ack(l_rom_ack), .rom_data(l_rom_data), .lb_we(l_lb_we), .lb_x(l_lb_x),
    .lb_color(l_lb_color), .lb_prio(l_lb_prio), .lb_flip(l_lb_flip), .lb_data(l_lb_data),
    .busy(l_busy), .overflow(l_overflow), .span_count(l_span_count));

  typedef struct packed {
    logic [9:0]  x;
    logic [6:0]  color;
    logic        prio;
    logic        flip;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_ex;
  logic [63:0] tbl [512];
  int          n_vec = 0, n_bad = 0;
  int          we_cnt = 0, l_we_cnt = 0, acks = 0, req_rises = 0, busy_ces = 0, ack_delay = 2;
  int          rise_acks[$];
  logic [8:0]  we_idx = 9'd0;
  logic        req_d = 1'b0, first_seen = 1'b0;
  logic [24:0] first_addr = 25'd0, cap = 25'd0;
  int          exp_n, we0, l_we0, ce0, rises0, acks0;

  initial begin
    forever #5 clk = ~clk;
  end

  // ce every third clk, updated on the falling edge
  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      ce = (k == 0);
      k = (k == 2) ? 0 : k + 1;
    end
  end

  // attribute table: entry at obj_idx appears one ce later
  always @(posedge clk) begin
    if (ce) begin
      obj_in   <= tbl[obj_idx];
      l_obj_in <= tbl[l_obj_idx];
    end
  end

  always @(posedge clk) begin
    if (ce && busy) busy_ces <= busy_ces + 1;
  end

  function automatic logic [63:0] romf(input logic [24:0] a);
    return {7'h5A, a, 7'h33, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] mk_ent(input logic [8:0] oy, input logic [1:0] hl, input logic [1:0] wl,
                                         input logic [15:0] code, input logic [6:0] color,
                                         input logic pr, input logic fx, input logic fy,
                                         input logic [9:0] ox);
    logic [63:0] e;
    e = 64'hFC00_FC00_0000_E000;
    e[8:0] = oy; e[10:9] = hl; e[12:11] = wl; e[31:16] = code;
    e[38:32] = color; e[39] = pr; e[40] = fx; e[41] = fy; e[57:48] = ox;
    return e;
  endfunction

  task automatic fill_misses(input logic [8:0] ve);
    for (int i = 0; i < 512; i++)
      tbl[i] = mk_ent(9'h100 - ve, 2'd0, 2'd1, 16'(i), 7'd0, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  // reference line walk straight from the object/scanline arithmetic
  task automatic model_line(input logic [8:0] ve, output int n);
    logic [63:0] e;
    logic [8:0]  h, rel, rowy;
    logic [15:0] code;
    logic [24:0] addr;
    exp_t        ex;
    int          idx, wi, col;
    n = 0;
    idx = 0;
    while (idx < 512) begin
      e = tbl[idx];
      h = 9'd16 << e[10:9];
      wi = 1 << e[12:11];
      rel = ve + e[8:0] + h;
      if (rel < h) begin
        rowy = e[41] ? (h - 9'd1 - rel) : rel;
        for (int s = 0; s < wi; s++) begin
          col = e[40] ? (wi - 1 - s) : s;
          code = e[31:16] + 16'(rowy[8:4]) + 16'(col * 8);
          addr = BASE + {2'b00, code, rowy[3:0], 3'b000};
          ex.x = e[57:48] + 10'(16 * s);
          ex.color = e[38:32];
          ex.prio = e[39];
          ex.flip = e[40];
          ex.data = romf(addr);
          q.push_back(ex);
          n++;
        end
      end
      idx += wi;
    end
  endtask

  // main ROM: acks after ack_delay clks, data derived from the requested address
  initial begin
    forever begin
      @(negedge clk);
      if (rom_req) begin
        cap = rom_addr;
        if (!first_seen) begin
          first_addr = cap;
          first_seen = 1'b1;
        end
        repeat (ack_delay) @(negedge clk);
        rom_data = romf(cap);
        rom_ack = 1'b1;
        @(negedge clk);
        rom_ack = 1'b0;
        acks++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (l_rom_req) begin
        l_rom_data = romf(l_rom_addr);
        l_rom_ack = 1'b1;
        @(negedge clk);
        l_rom_ack = 1'b0;
      end
    end
  end

  // write monitor and request-edge tracker
  initial begin
    forever begin
      @(negedge clk);
      if (lb_we) begin
        we_cnt++;
        we_idx = obj_idx;
        if (q.size() == 0) begin
          chk("we_extra", 64'(lb_we), 64'd0);
        end else begin
          mon_ex = q.pop_front();
          chk("lb_x", 64'(lb_x), 64'(mon_ex.x));
          chk("lb_color", 64'(lb_color), 64'(mon_ex.color));
          chk("lb_prio", 64'(lb_prio), 64'(mon_ex.prio));
          chk("lb_flip", 64'(lb_flip), 64'(mon_ex.flip));
          chk("lb_data", lb_data, mon_ex.data);
        end
      end
      if (l_lb_we) l_we_cnt++;
      if (rom_req && !req_d) begin
        req_rises++;
        rise_acks.push_back(acks);
      end
      req_d = rom_req;
    end
  end

  task automatic start_line(input logic [8:0] vl, input logic fs);
    v_line = vl;
    flip_screen = fs;
    @(negedge clk); #1;
    while (ce !== 1'b1) begin
      @(negedge clk); #1;
    end
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((busy || l_busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(busy | l_busy), 64'd0);
    repeat (6) @(negedge clk);
  endtask

  task automatic run_line(input logic [8:0] vl, input logic fs);
    q.delete();
    model_line(vl ^ {9{fs}}, exp_n);
    we0 = we_cnt; l_we0 = l_we_cnt; ce0 = busy_ces; rises0 = req_rises;
    first_seen = 1'b0;
    start_line(vl, fs);
    wait_idle("line_done");
    chk("q_left", 64'(q.size()), 64'd0);
    chk("we_count", 64'(we_cnt - we0), 64'(exp_n));
    chk("span_count", 64'(span_count), 64'(exp_n));
    chk("overflow", 64'(overflow), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (4) @(negedge clk);
    chk("rst_idx", 64'(obj_idx), 64'd0);
    chk("rst_req", 64'(rom_req), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_we", 64'(lb_we), 64'd0);
    chk("rst_x", 64'(lb_x), 64'd0);
    chk("rst_data", lb_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_span", 64'(span_count), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // all misses: 256 entries at stride 2, two ce each
    fill_misses(9'd0);
    run_line(9'd0, 1'b0);
    chk("miss_ces", 64'(busy_ces - ce0), 64'd512);
    chk("miss_reqs", 64'(req_rises - rises0), 64'd0);

    // single 16x16 object
    fill_misses(9'd4);
    tbl[0] = mk_ent(9'h1F0, 2'd0, 2'd0, 16'h0100, 7'h15, 1'b1, 1'b0, 1'b0, 10'd40);
    run_line(9'd4, 1'b0);
    chk("one_addr", 64'(first_addr), 64'(BASE + 25'h0008020));
    chk("one_x", 64'(lb_x), 64'd40);

    // 4-wide, x-flipped: columns 3..0; budget instance stops at 3
    tbl[0] = mk_ent(9'h1F0, 2'd0, 2'd2, 16'h0100, 7'h2A, 1'b0, 1'b1, 1'b0, 10'd40);
    run_line(9'd4, 1'b0);
    chk("flip_addr", 64'(first_addr), 64'(BASE + 25'h0008C20));
    chk("flip_x", 64'(lb_x), 64'd88);
    chk("next_idx", 64'(we_idx), 64'd4);
    chk("lim_we", 64'(l_we_cnt - l_we0), 64'd3);
    chk("lim_ovf", 64'(l_overflow), 64'd1);
    chk("lim_busy", 64'(l_busy), 64'd0);
    chk("lim_span", 64'(l_span_count), 64'd3);

    // abort in-flight fetch: late ack is dropped, refetch follows it
    fill_misses(9'd4);
    tbl[0] = mk_ent(9'h1F0, 2'd0, 2'd0, 16'h0100, 7'h15, 1'b1, 1'b0, 1'b0, 10'd40);
    q.delete();
    model_line(9'd4, exp_n);
    ack_delay = 20;
    we0 = we_cnt; rises0 = req_rises; acks0 = acks;
    start_line(9'd4, 1'b0);
    chk("lim_ovf_clr", 64'(l_overflow), 64'd0);
    t = 0;
    while (!rom_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stale_req_up", 64'(rom_req), 64'd1);
    start_line(9'd4, 1'b0);
    chk("stale_req_dn", 64'(rom_req), 64'd0);
    wait_idle("stale_done");
    chk("stale_we", 64'(we_cnt - we0), 64'(exp_n));
    chk("stale_q", 64'(q.size()), 64'd0);
    chk("stale_rises", 64'(req_rises - rises0), 64'd2);
    chk("stale_order", 64'(rise_acks[rises0 + 1]), 64'(acks0 + 1));
    chk("stale_acks", 64'(acks - acks0), 64'd2);
    ack_delay = 2;

    // flipped screen, flipy and the h-1 boundary
    fill_misses(9'h1FF);
    tbl[0] = mk_ent(9'h1E6, 2'd1, 2'd1, 16'h0200, 7'h4C, 1'b0, 1'b0, 1'b1, 10'd1000);
    tbl[2] = mk_ent(9'h000, 2'd3, 2'd0, 16'hFFFF, 7'h01, 1'b1, 1'b1, 1'b0, 10'd5);
    tbl[3] = mk_ent(9'h001, 2'd3, 2'd0, 16'h1234, 7'h02, 1'b0, 1'b0, 1'b0, 10'd9);
    run_line(9'd0, 1'b1);
    chk("fs_addr", 64'(first_addr), 64'(BASE + 25'h00100D0));
    chk("fs_spans", 64'(span_count), 64'd3);
    chk("fs_x", 64'(lb_x), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
